// File: rtl/maxpool_stream.sv
// Streaming 2x2 stride-2 pooling over a square IFM_SIZE x IFM_SIZE map in row-major order.
// Define MAXPOOL_AVG_MODE_EN to add the pool_mode port and average pooling alongside max pooling.
module maxpool_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int IFM_SIZE   = 28
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
`ifdef MAXPOOL_AVG_MODE_EN
  input  logic                  pool_mode,
`endif
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  frame_done
);

`ifdef MAXPOOL_AVG_MODE_EN
  localparam int BUF_W = DATA_WIDTH + 1;
`else
  localparam int BUF_W = DATA_WIDTH;
`endif
  localparam int CNT_W = $clog2(IFM_SIZE);
  localparam int LB_N  = IFM_SIZE / 2;
  localparam int LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(IFM_SIZE - 1);

  typedef enum logic {EVEN_ROW, ODD_ROW} state_t;

  function automatic logic signed [BUF_W-1:0] pool_max(
    input logic signed [BUF_W-1:0] a,
    input logic signed [BUF_W-1:0] b
  );
    return (a >= b) ? a : b;
  endfunction

`ifdef MAXPOOL_AVG_MODE_EN
  function automatic logic signed [DATA_WIDTH-1:0] pool_avg(
    input logic signed [BUF_W-1:0] a,
    input logic signed [BUF_W-1:0] b,
    input logic signed [BUF_W-1:0] c
  );
    logic signed [DATA_WIDTH+1:0] sum;
    sum = (DATA_WIDTH+2)'(a) + (DATA_WIDTH+2)'(b) + (DATA_WIDTH+2)'(c);
    return DATA_WIDTH'(sum >>> 2);
  endfunction
`endif

  state_t                    state_p0, state_d;
  logic [CNT_W-1:0]          col_p0, row_p0;
  logic signed [BUF_W-1:0]   pair_p0;
  logic signed [BUF_W-1:0]   line_buf_p0 [LB_N];
  logic [LB_AW-1:0]          lb_idx;
  logic signed [DATA_WIDTH-1:0] sample;
  logic signed [BUF_W-1:0]   sample_x, lb_rd, even_res;
  logic signed [DATA_WIDTH-1:0] odd_res;
  logic                      accept, col_last, row_last, emit;
  logic                      vld_p1, done_p1;
  logic [DATA_WIDTH-1:0]     data_p1;
`ifdef MAXPOOL_AVG_MODE_EN
  logic                      mode_p0;
`endif

  // A sample arriving with clear belongs to the abandoned map and is dropped.
  assign accept   = in_valid & ~clear;
  assign col_last = (col_p0 == LAST);
  assign row_last = (row_p0 == LAST);
  assign sample   = in_data;
  assign sample_x = BUF_W'(sample);
  assign lb_idx   = LB_AW'(col_p0 >> 1);
  assign lb_rd    = line_buf_p0[lb_idx];
  assign emit     = accept & (state_p0 == ODD_ROW) & col_p0[0];

  always_comb begin
    even_res = pool_max(pair_p0, sample_x);
    odd_res  = DATA_WIDTH'(pool_max(pool_max(lb_rd, pair_p0), sample_x));
`ifdef MAXPOOL_AVG_MODE_EN
    if (mode_p0) begin
      even_res = pair_p0 + sample_x;
      odd_res  = pool_avg(lb_rd, pair_p0, sample_x);
    end
`endif
  end

  always_comb begin
    state_d = state_p0;
    if (clear)
      state_d = EVEN_ROW;
    else if (accept && col_last)
      state_d = (state_p0 == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
  end

  // Stage p0: position counters, row-parity state, pair register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0 <= EVEN_ROW;
      col_p0   <= '0;
      row_p0   <= '0;
      pair_p0  <= '0;
`ifdef MAXPOOL_AVG_MODE_EN
      mode_p0  <= 1'b0;
`endif
    end else begin
      state_p0 <= state_d;
      if (clear) begin
        col_p0 <= '0;
        row_p0 <= '0;
      end else if (accept) begin
        if (col_last) begin
          col_p0 <= '0;
          row_p0 <= row_last ? '0 : row_p0 + 1'b1;
        end else begin
          col_p0 <= col_p0 + 1'b1;
        end
        if (!col_p0[0])
          pair_p0 <= sample_x;
`ifdef MAXPOOL_AVG_MODE_EN
        if (col_p0 == '0 && row_p0 == '0)
          mode_p0 <= pool_mode;
`endif
      end
    end
  end

  // Every entry is rewritten on an even row before the following odd row reads it.
  always_ff @(posedge clk) begin
    if (accept && state_p0 == EVEN_ROW && col_p0[0])
      line_buf_p0[lb_idx] <= even_res;
  end

  // Stage p1: registered result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      data_p1 <= '0;
    end else if (clear) begin
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      vld_p1  <= emit;
      done_p1 <= emit & row_last & col_last;
      if (emit)
        data_p1 <= odd_res;
    end
  end

  assign out_valid  = vld_p1;
  assign out_data   = data_p1;
  assign frame_done = done_p1;

endmodule

// File: tb/tb_maxpool_stream.sv
// Scoreboard bench for maxpool_stream at IFM_SIZE=4: the driver queues hand-computed results,
// a negedge monitor pops and checks data, frame_done and the cycle each result appears.
module tb_maxpool_stream;

  localparam int DW  = 32;
  localparam int IFM = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          frame_done;
`ifdef MAXPOOL_AVG_MODE_EN
  logic          pool_mode = 1'b0;
`endif

  maxpool_stream #(.DATA_WIDTH(DW), .IFM_SIZE(IFM)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
`ifdef MAXPOOL_AVG_MODE_EN
    .pool_mode  (pool_mode),
`endif
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          fd;
    int            due;
    string         name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_out: got data=%h fd=%b, required no output", out_data, frame_done);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_data !== e.data || frame_done !== e.fd || cyc != e.due) begin
          failed++;
          $display("FAIL %s: got data=%h fd=%b cyc=%0d, required data=%h fd=%b cyc=%0d",
                   e.name, out_data, frame_done, cyc, e.data, e.fd, e.due);
        end
      end
    end else if (!reset && frame_done) begin
      tests++;
      failed++;
      $display("FAIL lone_frame_done: got fd=1 with out_valid=0, required fd=0");
    end
  end

  task automatic drive(input logic [DW-1:0] v, input bit push, input logic [DW-1:0] e,
                       input bit fd, input string name);
    exp_t x;
    in_valid = 1'b1;
    in_data  = v;
    if (push) begin
      x.data = e; x.fd = fd; x.due = cyc + 1; x.name = name;
      exp_q.push_back(x);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic feed_map(input logic [DW-1:0] v[16], input logic [DW-1:0] e[4],
                          input bit gaps, input string name);
    for (int i = 0; i < 16; i++) begin
      bit push;
      int k;
      push = ((i / 4) % 2 == 1) && (i % 2 == 1);
      k = (i / 8) * 2 + (i % 4) / 2;
      drive(v[i], push, e[k], i == 15, $sformatf("%s_r%0d", name, k));
      if (gaps) idle(1);
    end
  endtask

  task automatic check_out(input string name, input logic ov, input logic [DW-1:0] od,
                           input logic fd);
    tests++;
    if (out_valid !== ov || out_data !== od || frame_done !== fd) begin
      failed++;
      $display("FAIL %s: got ov=%b data=%h fd=%b, required ov=%b data=%h fd=%b",
               name, out_valid, out_data, frame_done, ov, od, fd);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, queue=%0d", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] v [16];
    logic [DW-1:0] e [4];

    // asynchronous reset, checked before any clock edge
    #1 reset = 1'b1;
    #1 check_out("reset_state", 1'b0, '0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);
    check_out("idle_after_reset", 1'b0, '0, 1'b0);

    for (int i = 0; i < 16; i++) v[i] = DW'(i);
    e = '{32'd5, 32'd7, 32'd13, 32'd15};
    feed_map(v, e, 1'b0, "ramp");
    idle(2);
    feed_map(v, e, 1'b1, "ramp_gaps");
    idle(2);

    for (int i = 0; i < 16; i++) v[i] = 32'hFFFF_FFF0;
    v[0] = 32'h8000_0000; v[3] = 32'h8000_0000; v[13] = 32'h8000_0000; v[11] = 32'h8000_0000;
    e = '{32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0};
    feed_map(v, e, 1'b0, "min_neg");
    idle(1);

    v = '{32'hFFFF_FFFB, 32'd3, 32'd7, 32'hFFFF_FFFF,
          32'h8000_0000, 32'd1, 32'hFFFF_FFFE, 32'hFFFF_FFFD,
          32'hFFFF_FFF8, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
          32'hFFFF_FFF6, 32'hFFFF_FFFC, 32'hFFFF_FFFE, 32'd0};
    e = '{32'd3, 32'd7, 32'hFFFF_FFFC, 32'h7FFF_FFFF};
    feed_map(v, e, 1'b1, "mixed_sign");
    idle(2);

    // reset abandons a partial map
    for (int i = 0; i < 7; i++) drive(DW'(i), i == 5, 32'd5, 1'b0, "pre_reset");
    reset = 1'b1;
    #1 check_out("mid_map_reset", 1'b0, '0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);
    for (int i = 0; i < 16; i++) v[i] = DW'(i);
    e = '{32'd5, 32'd7, 32'd13, 32'd15};
    feed_map(v, e, 1'b0, "post_reset");
    idle(2);

    // clear at row 1, column 3 drops that sample and restarts the map
    for (int i = 0; i < 7; i++) drive(DW'(100 + i), i == 5, 32'd105, 1'b0, "pre_clear");
    clear = 1'b1;
    drive(32'd107, 1'b0, '0, 1'b0, "cleared");
    clear = 1'b0;
    check_out("after_clear", 1'b0, 32'd105, 1'b0);
    feed_map(v, e, 1'b0, "post_clear");
    idle(2);

`ifdef MAXPOOL_AVG_MODE_EN
    pool_mode = 1'b1;
    e = '{32'd2, 32'd4, 32'd10, 32'd12};
    feed_map(v, e, 1'b0, "avg_ramp");
    for (int i = 0; i < 16; i++) v[i] = '0;
    v[0] = 32'hFFFF_FFFF; v[1] = 32'hFFFF_FFFE; v[4] = 32'hFFFF_FFFD; v[5] = 32'hFFFF_FFFC;
    e = '{32'hFFFF_FFFD, 32'd0, 32'd0, 32'd0};
    feed_map(v, e, 1'b0, "avg_neg");
    pool_mode = 1'b0;
    idle(2);
`endif

    idle(3);
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain: got %0d results still pending, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/maxpool_stream.md
MAXPOOL_STREAM -- requirements
Module: maxpool_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of every data sample and the result.
REQ-002 Parameter IFM_SIZE, default 28, width and height of the square input map; the value SHALL be even.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, asynchronous, active-high reset.
REQ-005 Port clear, input, 1, synchronous frame restart.
REQ-006 Port in_valid, input, 1, in_data holds a sample this cycle.
REQ-007 Port in_data, input, DATA_WIDTH, conv-stage output sample, signed two's complement, row-major order.
REQ-008 Port out_valid, output, 1, out_data holds a pooled result this cycle.
REQ-009 Port out_data, output, DATA_WIDTH, pooled 2x2 result, signed.
REQ-010 Port frame_done, output, 1, one-cycle pulse with the last result of a map.

Function
REQ-011 The block SHALL apply 2x2 stride-2 pooling and emit (IFM_SIZE/2)^2 results per input map.
REQ-012 A column counter (0..IFM_SIZE-1) and a row counter (0..IFM_SIZE-1) SHALL advance only on cycles with in_valid=1; gaps of any length are legal.
REQ-013 Column wrap: at column IFM_SIZE-1 the column counter SHALL go to 0 and the row counter SHALL increment; at row IFM_SIZE-1 the row counter SHALL also wrap to 0 (next map).
REQ-014 FSM states: EVEN_ROW (row bit0=0), ODD_ROW (row bit0=1); the transition happens on the column wrap.
REQ-015 Even column (either state): the sample SHALL be held in a pair register.
REQ-016 EVEN_ROW, odd column: signed max(pair register, sample) SHALL be written to line buffer entry col/2 (IFM_SIZE/2 entries).
REQ-017 ODD_ROW, odd column: result = signed max(line buffer[col/2], pair register, sample).
REQ-018 out_data and out_valid SHALL be registered, with out_valid=1 exactly one cycle after the accepting edge.
REQ-019 Equal operands SHALL give the same value; the comparison SHALL be signed, so 0x80000000 is the minimum.
REQ-020 frame_done SHALL be 1 in the same cycle as out_valid for row IFM_SIZE-1, column IFM_SIZE-1; otherwise 0.
REQ-021 No backpressure: each result is valid for one cycle only, and the consumer SHALL accept every result.
REQ-022 clear=1 SHALL zero the counters and set EVEN_ROW, out_valid=0 and frame_done=0 on that edge.
REQ-023 A sample presented together with clear SHALL be discarded.
REQ-024 clear SHALL NOT alter line buffer contents, which are overwritten before they are read.

Reset
REQ-025 While reset=1 (asynchronous): counters=0, state=EVEN_ROW, pair register=0, out_data=0, out_valid=0, frame_done=0.
REQ-026 The line buffer need not be reset.
REQ-027 A reset asserted mid-map SHALL abandon that map; the first in_valid after release SHALL be treated as row 0, column 0.

Configuration
REQ-028 Macro MAXPOOL_AVG_MODE_EN defined: an input port pool_mode (1 bit) SHALL exist.
REQ-029 pool_mode=0 selects max pooling.
REQ-030 pool_mode=1 selects average pooling: sum of the four samples in DATA_WIDTH+2 bits, arithmetic right shift by 2, truncated to DATA_WIDTH.
REQ-031 In average mode, the line buffer and pair register SHALL hold partial sums of width DATA_WIDTH+1.
REQ-032 pool_mode SHALL be sampled only at row 0, column 0 and held for the map.
REQ-033 Macro MAXPOOL_AVG_MODE_EN undefined: no pool_mode port, max pooling only, and buffers DATA_WIDTH wide.

Verification
REQ-034 IFM_SIZE=4, continuous stream of values 0..15 -> out_data 5,7,13,15 on four out_valid pulses; frame_done with the value 15.
REQ-035 Same map with in_valid toggling 1,0,1,0 -> identical results, each exactly one cycle after its accepting edge.
REQ-036 All samples 0xFFFFFFF0 except one 0x80000000 per window -> every result 0xFFFFFFF0 (signed compare).
REQ-037 Reset pulse after sample 6, then 16 fresh samples 0..15 -> results 5,7,13,15 with no stale output.
REQ-038 clear asserted at row 1, column 3, with in_valid=1 -> that sample dropped; the next map pools from row 0, column 0 correctly.
REQ-039 MAXPOOL_AVG_MODE_EN defined, pool_mode=1, samples 0..15 -> 2,4,10,12; window {-1,-2,-3,-4} -> -3.
